// File: rtl/opto_pkg.sv
// Shared types and widths for the opto-wheel calibration RAM read path.
package opto_pkg;

  localparam int unsigned OPTO_ADDR_W = 8;
  localparam int unsigned OPTO_DATA_W = 8;

  // Bulk dump controller states
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } dumpState_e;

  // Owner of a RAM read travelling down the latency pipeline
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_LOOKUP,
    TAG_DUMP
  } tag_e;

endpackage

// File: rtl/opto_rd_fifo2.sv
// Two-entry valid/ready buffer holding dump read data for the host stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write pushData this cycle (ignored when full and not popping)
//   pushData   : data to store
//   pop        : head consumed this cycle (ignored when empty)
//   headData   : oldest stored entry
//   headValid  : buffer holds at least one entry
//   count      : number of stored entries, 0..2
module opto_rd_fifo2 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [DATA_W-1:0] headData,
  output logic              headValid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wrPtr;
  logic              rdPtr;
  logic [1:0]        cnt;
  logic              doPush;
  logic              doPop;

  assign doPop  = pop && (cnt != 2'd0);
  assign doPush = push && ((cnt != 2'd2) || doPop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= ~wrPtr;
      end
      if (doPop) begin
        rdPtr <= ~rdPtr;
      end
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign headData  = mem[rdPtr];
  assign headValid = (cnt != 2'd0);
  assign count     = cnt;

endmodule

// File: rtl/opto_ram_reader.sv
// Read-side controller for the opto-wheel calibration RAM. Encoder lookups
// get the read port whenever they ask; a bulk dump of a wrapping address
// window streams out over valid/ready using the remaining read slots.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_lookup_req/addr    : single-cycle lookup request and address
//   o_lookup_data/valid  : lookup result, RAM_LAT+1 cycles after request
//   i_dump_start/base/len: dump start pulse, first address, byte count 0..256
//   o_dump_data/valid    : dump stream, i_dump_ready from sink
//   o_dump_busy/done     : dump in progress / one-cycle completion pulse
//   o_ram_rdaddr/rden    : RAM read address and read enable
//   i_ram_rdata          : RAM read data, valid RAM_LAT cycles after issue
module opto_ram_reader
  import opto_pkg::*;
#(
  parameter int          RAM_LAT = 1,
  parameter int unsigned ADDR_W  = OPTO_ADDR_W,
  parameter int unsigned DATA_W  = OPTO_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lookup_req,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic [DATA_W-1:0] o_lookup_data,
  output logic              o_lookup_valid,
  input  logic              i_dump_start,
  input  logic [ADDR_W-1:0] i_dump_base,
  input  logic [ADDR_W:0]   i_dump_len,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic              o_dump_busy,
  output logic              o_dump_done,
  output logic [ADDR_W-1:0] o_ram_rdaddr,
  output logic              o_ram_rden,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  dumpState_e        state;
  dumpState_e        stateNext;
  tag_e              tagPipe [RAM_LAT];
  tag_e              issueTag;
  tag_e              landTag;
  logic [ADDR_W-1:0] baseReg;
  logic [ADDR_W-1:0] lastAddr;
  logic [ADDR_W-1:0] dumpAddr;
  logic [CNT_W-1:0]  lenReg;
  logic [CNT_W-1:0]  issuedCnt;
  logic [CNT_W-1:0]  acceptedCnt;
  logic [CNT_W-1:0]  acceptedNext;
  logic [1:0]        inflightDump;
  logic [1:0]        fifoCount;
  logic [2:0]        creditUsed;
  logic              dumpIssue;
  logic              dumpPop;
  logic              latchStart;
  logic              fifoValid;
  logic [DATA_W-1:0] fifoData;

  assign landTag      = tagPipe[RAM_LAT-1];
  assign dumpPop      = fifoValid && i_dump_ready;
  assign acceptedNext = acceptedCnt + CNT_W'(dumpPop);
  assign dumpAddr     = baseReg + issuedCnt[ADDR_W-1:0];
  assign creditUsed   = 3'(fifoCount) + 3'(inflightDump);

  // Dump reads still travelling through the RAM latency
  always_comb begin
    inflightDump = 2'd0;
    for (int i = 0; i < RAM_LAT; i++) begin
      if (tagPipe[i] == TAG_DUMP) begin
        inflightDump = inflightDump + 2'd1;
      end
    end
  end

  // Read-port arbitration: lookups always win. The dump credit counts the
  // slot freed by a same-cycle pop so ready-high streaming runs at full rate.
  always_comb begin
    dumpIssue    = (state == RUN) && !i_lookup_req && (issuedCnt < lenReg) &&
                   (creditUsed < (3'd2 + 3'(dumpPop)));
    issueTag     = TAG_NONE;
    o_ram_rden   = 1'b0;
    o_ram_rdaddr = lastAddr;
    if (i_lookup_req) begin
      issueTag     = TAG_LOOKUP;
      o_ram_rden   = 1'b1;
      o_ram_rdaddr = i_lookup_addr;
    end else if (dumpIssue) begin
      issueTag     = TAG_DUMP;
      o_ram_rden   = 1'b1;
      o_ram_rdaddr = dumpAddr;
    end
  end

  // Dump state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Dump next-state logic; starts are only honoured from IDLE
  always_comb begin
    stateNext  = state;
    latchStart = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_dump_start) begin
          if (i_dump_len == '0) begin
            stateNext = DONE;
          end else begin
            stateNext  = RUN;
            latchStart = 1'b1;
          end
        end
      end
      RUN: begin
        if (issuedCnt == lenReg) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (acceptedNext == lenReg) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Dump window and progress counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      baseReg     <= '0;
      lenReg      <= '0;
      issuedCnt   <= '0;
      acceptedCnt <= '0;
    end else if (latchStart) begin
      baseReg     <= i_dump_base;
      lenReg      <= i_dump_len;
      issuedCnt   <= '0;
      acceptedCnt <= '0;
    end else begin
      if (dumpIssue) begin
        issuedCnt <= issuedCnt + CNT_W'(1);
      end
      if (dumpPop) begin
        acceptedCnt <= acceptedNext;
      end
    end
  end

  // Tag pipeline tracks who owns the data landing RAM_LAT cycles later
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        tagPipe[i] <= TAG_NONE;
      end
      lastAddr <= '0;
    end else begin
      tagPipe[0] <= issueTag;
      for (int i = 1; i < RAM_LAT; i++) begin
        tagPipe[i] <= tagPipe[i-1];
      end
      if (o_ram_rden) begin
        lastAddr <= o_ram_rdaddr;
      end
    end
  end

  // Lookup result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lookup_valid <= 1'b0;
      o_lookup_data  <= '0;
    end else begin
      o_lookup_valid <= (landTag == TAG_LOOKUP);
      if (landTag == TAG_LOOKUP) begin
        o_lookup_data <= i_ram_rdata;
      end
    end
  end

  opto_rd_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (landTag == TAG_DUMP),
    .pushData  (i_ram_rdata),
    .pop       (dumpPop),
    .headData  (fifoData),
    .headValid (fifoValid),
    .count     (fifoCount)
  );

  assign o_dump_data  = fifoData;
  assign o_dump_valid = fifoValid;
  assign o_dump_busy  = (state == RUN) || (state == DRAIN);
  assign o_dump_done  = (state == DONE);

endmodule

// File: tb/tb_opto_ram_reader.sv
// Directed bench for opto_ram_reader with a scoreboard of expected lookup
// results and dump beats; RAM model holds addr ^ 8'hA5.
module tb_opto_ram_reader;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rstN;
  logic       lookupReq;
  logic [7:0] lookupAddr;
  logic [7:0] lookupData;
  logic       lookupValid;
  logic       dumpStart;
  logic [7:0] dumpBase;
  logic [8:0] dumpLen;
  logic [7:0] dumpData;
  logic       dumpValid;
  logic       dumpReady;
  logic       dumpBusy;
  logic       dumpDone;
  logic [7:0] ramRdaddr;
  logic       ramRden;
  logic [7:0] ramRdata;

  logic [7:0] ramMem [256];
  logic [7:0] addrQ;

  int checks    = 0;
  int errors    = 0;
  int doneCount = 0;
  logic [7:0] lookExp [$];
  logic [7:0] dumpExp [$];
  logic       heldPrev = 1'b0;
  logic [7:0] heldData = 8'h00;

  opto_ram_reader #(
    .RAM_LAT (LAT),
    .ADDR_W  (8),
    .DATA_W  (8)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_lookup_req   (lookupReq),
    .i_lookup_addr  (lookupAddr),
    .o_lookup_data  (lookupData),
    .o_lookup_valid (lookupValid),
    .i_dump_start   (dumpStart),
    .i_dump_base    (dumpBase),
    .i_dump_len     (dumpLen),
    .o_dump_data    (dumpData),
    .o_dump_valid   (dumpValid),
    .i_dump_ready   (dumpReady),
    .o_dump_busy    (dumpBusy),
    .o_dump_done    (dumpDone),
    .o_ram_rdaddr   (ramRdaddr),
    .o_ram_rden     (ramRden),
    .i_ram_rdata    (ramRdata)
  );

  always #5 clk = ~clk;

  // RAM model: address registered on rden, data read out asynchronously
  always @(posedge clk) begin
    if (ramRden) addrQ <= ramRdaddr;
  end
  assign ramRdata = ramMem[addrQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor sampled on the falling edge
  always @(negedge clk) begin
    if (!rstN) begin
      heldPrev = 1'b0;
    end else begin
      if (lookupValid) begin
        if (lookExp.size() == 0) chk("lookup_unexpected", 32'(1), 32'(0));
        else chk("lookup_data", 32'(lookupData), 32'(lookExp.pop_front()));
      end
      if (heldPrev) begin
        chk("hold_valid", 32'(dumpValid), 32'(1));
        chk("hold_data", 32'(dumpData), 32'(heldData));
      end
      if (dumpValid && dumpReady) begin
        if (dumpExp.size() == 0) chk("dump_unexpected", 32'(1), 32'(0));
        else chk("dump_data", 32'(dumpData), 32'(dumpExp.pop_front()));
      end
      heldPrev = dumpValid && !dumpReady;
      heldData = dumpData;
      if (dumpDone) begin
        doneCount++;
        chk("busy_on_done", 32'(dumpBusy), 32'(0));
      end
    end
  end

  function automatic logic [31:0] allOuts();
    return 32'({lookupData, lookupValid, dumpData, dumpValid,
                dumpBusy, dumpDone, ramRdaddr, ramRden});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startDump(input logic [7:0] base, input int len);
    logic [7:0] a;
    for (int i = 0; i < len; i++) begin
      a = 8'(int'(base) + i);
      dumpExp.push_back(a ^ 8'hA5);
    end
    dumpStart = 1'b1;
    dumpBase  = base;
    dumpLen   = 9'(len);
    tick();
    dumpStart = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, input int d0);
    for (int c = 0; c < budget && doneCount == d0; c++) @(negedge clk);
    chk(tag, 32'(doneCount != d0), 32'(1));
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0] seen;
    logic [7:0] a;
    int d0;
    int issues;

    for (int i = 0; i < 256; i++) ramMem[i] = 8'(i) ^ 8'hA5;
    rstN = 1'b0; lookupReq = 1'b0; lookupAddr = 8'h00;
    dumpStart = 1'b0; dumpBase = 8'h00; dumpLen = 9'd0; dumpReady = 1'b0;
    #2;
    chk("reset_outputs", allOuts(), 32'(0));
    repeat (3) tick();
    rstN = 1'b1;
    tick();

    // Single lookup latency
    lookupReq = 1'b1; lookupAddr = 8'h10; lookExp.push_back(8'hB5);
    @(negedge clk); chk("lat_c0", 32'(lookupValid), 32'(0));
    tick(); lookupReq = 1'b0;
    @(negedge clk); chk("lat_c1", 32'(lookupValid), 32'(0));
    @(negedge clk); chk("lat_c2", 32'(lookupValid), 32'(1));
    tick();

    // Back-to-back lookups return at full rate
    seen = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        lookupReq = 1'b1; lookupAddr = 8'(i); lookExp.push_back(8'(i) ^ 8'hA5);
      end else lookupReq = 1'b0;
      @(negedge clk); seen[i] = lookupValid;
      tick();
    end
    chk("b2b_pattern", 32'(seen), 32'(8'b0011_1100));
    chk("lookup_drained", 32'(lookExp.size()), 32'(0));

    // Wrapping dump FE..01
    dumpReady = 1'b1; d0 = doneCount;
    startDump(8'hFE, 4);
    @(negedge clk); chk("busy_run", 32'(dumpBusy), 32'(1));
    waitDone("wrap_done", 50, d0);
    chk("wrap_beats", 32'(dumpExp.size()), 32'(0));
    chk("wrap_one_done", 32'(doneCount - d0), 32'(1));

    // Full 256 dump with toggling ready and injected lookups
    d0 = doneCount;
    startDump(8'h80, 256);
    for (int c = 0; c < 4000 && doneCount == d0; c++) begin
      dumpReady = (c % 2 == 0);
      if (c % 7 == 0) begin
        a = 8'($urandom_range(0, 255));
        lookupReq = 1'b1; lookupAddr = a; lookExp.push_back(a ^ 8'hA5);
      end else lookupReq = 1'b0;
      tick();
    end
    lookupReq = 1'b0; dumpReady = 1'b1;
    chk("full_done", 32'(doneCount != d0), 32'(1));
    repeat (4) tick();
    chk("full_beats", 32'(dumpExp.size()), 32'(0));
    chk("full_lookups", 32'(lookExp.size()), 32'(0));
    chk("full_one_done", 32'(doneCount - d0), 32'(1));

    // Zero-length dump
    d0 = doneCount;
    dumpStart = 1'b1; dumpBase = 8'h00; dumpLen = 9'd0;
    @(negedge clk); chk("len0_c0", 32'(dumpDone), 32'(0));
    tick(); dumpStart = 1'b0;
    @(negedge clk); chk("len0_c1", 32'(dumpDone), 32'(1));
    chk("len0_no_valid", 32'(dumpValid), 32'(0));
    repeat (3) tick();
    chk("len0_one_done", 32'(doneCount - d0), 32'(1));

    // Start while busy is ignored
    d0 = doneCount;
    startDump(8'h40, 16);
    repeat (3) tick();
    dumpStart = 1'b1; dumpBase = 8'h80; dumpLen = 9'd10;
    tick(); dumpStart = 1'b0;
    waitDone("busy_start_done", 100, d0);
    chk("busy_start_beats", 32'(dumpExp.size()), 32'(0));
    chk("busy_start_one_done", 32'(doneCount - d0), 32'(1));

    // Backpressure: issues stop once two beats are buffered
    d0 = doneCount;
    startDump(8'h20, 16);
    repeat (4) tick();
    dumpReady = 1'b0; issues = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 4 && ramRden) issues++;
      tick();
    end
    chk("bp_no_issue", 32'(issues), 32'(0));
    chk("bp_valid_held", 32'(dumpValid), 32'(1));
    dumpReady = 1'b1;
    waitDone("bp_done", 100, d0);
    chk("bp_beats", 32'(dumpExp.size()), 32'(0));

    // Asynchronous reset mid-dump
    startDump(8'h00, 16);
    for (int c = 0; c < 100 && dumpExp.size() > 11; c++) @(negedge clk);
    chk("rst_reached_beat5", 32'(dumpExp.size() <= 11), 32'(1));
    @(posedge clk); #3;
    rstN = 1'b0;
    #1;
    chk("rst_mid_outputs", allOuts(), 32'(0));
    dumpExp.delete();
    d0 = doneCount;
    repeat (2) tick();
    rstN = 1'b1;
    repeat (10) tick();
    chk("rst_no_done", 32'(doneCount - d0), 32'(0));
    chk("rst_no_valid", 32'(dumpValid), 32'(0));
    startDump(8'h33, 3);
    waitDone("post_rst_done", 50, d0);
    chk("post_rst_beats", 32'(dumpExp.size()), 32'(0));
    chk("post_rst_one_done", 32'(doneCount - d0), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
